hazard_stall_ctrl: RTL
======================

Name: hazard_stall_ctrl

Overview:
Pipeline sequencing controller for the 5-stage MIPS core; pairs with the operand-forwarding unit. Covers hazards that forwarding cannot: load-use, branch-in-ID operand dependencies, and occupancy of the multi-cycle mult/div unit. Drives PC/IF-ID write enables, ID-EX bubble insertion, IF-ID flush and the mult/div start strobe.

Parameters:
MULDIV_LAT, 8, cycles the mult/div unit is busy after start (>=2)
CNT_W, $clog2(MULDIV_LAT+1), busy counter width

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
Rs_ID  input  5  rs of instruction in ID
Rt_ID  input  5  rt of instruction in ID
UsesRt_ID  input  1  ID instruction reads rt as source
Dst_EX  input  5  destination register in EX
RegWrite_EX  input  1  EX instruction writes a register
MemRead_EX  input  1  EX instruction is a load
Dst_MEM  input  5  destination register in MEM
MemRead_MEM  input  1  MEM instruction is a load
Branch_ID  input  1  ID instruction is a conditional branch (compare in ID)
BranchTaken_ID  input  1  ID branch resolved taken / jump
MulDiv_ID  input  1  ID instruction is mult/multu/div/divu
HiLoRead_ID  input  1  ID instruction is mfhi/mflo
PCWrite  output  1  PC update enable
IF_ID_Write  output  1  IF/ID register enable
ID_EX_Flush  output  1  insert bubble into ID/EX
IF_ID_Flush  output  1  squash fetched instruction
MulDiv_Start  output  1  one-cycle start pulse to mult/div unit
MulDiv_Busy  output  1  mult/div FSM not IDLE

Behaviour:
- Register 0 never causes a hazard (any match on index 0 ignored).
- rt comparisons apply only when UsesRt_ID=1.
- LoadUse = MemRead_EX && Dst_EX matches Rs_ID/Rt_ID.
- BrEX = Branch_ID && RegWrite_EX && Dst_EX matches; BrMEM = Branch_ID && MemRead_MEM && Dst_MEM matches (load feeding branch stalls 2 cycles total).
- MdStall = MulDiv_Busy && (HiLoRead_ID || MulDiv_ID).
- Stall = LoadUse | BrEX | BrMEM | MdStall. Stall => PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; else PCWrite=1, IF_ID_Write=1, ID_EX_Flush=0.
- IF_ID_Flush = BranchTaken_ID && !Stall (branch outcome ignored while stalled).
- Stall/flush outputs combinational from inputs and FSM state, zero added latency.
- Mult/div FSM, states IDLE, BUSY, DONE:
  IDLE: MulDiv_ID && !Stall -> MulDiv_Start=1 this cycle; next state BUSY, counter<=MULDIV_LAT-1.
  BUSY: counter decrements each cycle; at counter==0 -> DONE.
  DONE: one cycle, HI/LO valid; Busy still 1; -> IDLE. A stalled MulDiv_ID/mfhi issues the following cycle.
  MulDiv_Start never asserted outside IDLE; never asserted while Stall=1 (other hazard).
- Reset (async, any state incl. mid-BUSY): FSM IDLE, counter 0, MulDiv_Start=0, MulDiv_Busy=0; outputs then reflect inputs with idle FSM (PCWrite=1, IF_ID_Write=1, ID_EX_Flush=0, IF_ID_Flush=0 when no hazard). In-flight mult/div result discarded.
- Simultaneous LoadUse and MdStall: single stall, no double counting.

Optional Feature:
HAZARD_STATS_EN: adds output stall_cycles[31:0] (saturating count of cycles with Stall=1) and flush_count[31:0] (count of IF_ID_Flush pulses); both cleared by rst_n. Without the macro, ports and counters are absent; functional behaviour identical.

Decomposition:
- Shared package mips_pipe_pkg: REG_W=5, REG_ZERO=5'd0, enum md_state_t {MD_IDLE, MD_BUSY, MD_DONE}.
- Sub-module muldiv_sequencer: FSM + counter, inputs issue/stall, outputs start/busy. Hazard comparators stay in top.

Test Plan:
- lw $t0 in EX (MemRead_EX=1, Dst_EX=8), ID add rs=8 -> 1 cycle PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1, then normal.
- lw $t1 (Dst=9) then beq rs=9 in ID -> 2 stall cycles (BrEX then BrMEM), then branch taken -> IF_ID_Flush=1 one cycle.
- Load with Dst_EX=0 matching Rs_ID=0 -> no stall.
- MULDIV_LAT=8: issue div, mflo in ID next cycle -> Start pulse at cycle 0, Busy cycles 1..9, mflo stalled through DONE, issues the cycle Busy falls.
- rst_n low mid-BUSY (counter=3) -> immediately IDLE, Busy=0; after release mflo issues without stall.
- HAZARD_STATS_EN: run scenarios 1+2 -> stall_cycles=3, flush_count=1.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared pipeline types and helpers for the MIPS core
// Purpose: register-index width, the zero register, the mult/div FSM state
// enum and the register-dependency helper used by the hazard comparators.
package mips_pipe_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  // A producer targeting $zero never creates a dependency.
  function automatic logic reg_hit(logic [REG_W-1:0] src, logic [REG_W-1:0] dst);
    return (dst != REG_ZERO) && (src == dst);
  endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - mult/div occupancy sequencer (IDLE/BUSY/DONE)
// Purpose: tracks the multi-cycle mult/div unit and issues its start strobe.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   issue      : ID holds a mult/multu/div/divu
//   stall      : pipeline is stalled this cycle (instruction not leaving ID)
//   start      : one-cycle start pulse to the mult/div unit
//   busy       : FSM is not IDLE (BUSY or DONE)
module muldiv_sequencer
  import mips_pipe_pkg::*;
#(
  parameter int MULDIV_LAT = 8,
  parameter int CNT_W      = $clog2(MULDIV_LAT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic issue,
  input  logic stall,
  output logic start,
  output logic busy
);

  md_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  // Start only fires when the issuing instruction actually advances out of ID.
  assign start = (state_q == MD_IDLE) && issue && !stall;
  assign busy  = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (issue && !stall) begin
            state_q <= MD_BUSY;
            cnt_q   <= CNT_W'(MULDIV_LAT - 1);
            busy_q  <= 1'b1;
          end
        end
        MD_BUSY: begin
          if (cnt_q == '0) begin
            state_q <= MD_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        MD_DONE: begin
          // HI/LO valid this cycle; dependents still held, released next cycle.
          state_q <= MD_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= MD_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline stall/flush controller for the 5-stage MIPS core
// Purpose: detects load-use, branch-in-ID operand and mult/div occupancy
// hazards, drives PC/IF-ID enables, ID/EX bubble, IF/ID squash and mult/div start.
// Optional: HAZARD_STATS_EN adds stall_cycles (saturating) and flush_count.
// Ports:
//   clk, rst_n                          : clock, asynchronous active-low reset
//   Rs_ID, Rt_ID, UsesRt_ID             : ID source operands
//   Dst_EX, RegWrite_EX, MemRead_EX     : EX producer
//   Dst_MEM, MemRead_MEM                : MEM producer (loads only matter)
//   Branch_ID, BranchTaken_ID           : branch compare in ID and its outcome
//   MulDiv_ID, HiLoRead_ID              : mult/div issue and mfhi/mflo in ID
//   PCWrite, IF_ID_Write, ID_EX_Flush   : stall controls
//   IF_ID_Flush                         : squash fetched instruction
//   MulDiv_Start, MulDiv_Busy           : mult/div unit control/status
module hazard_stall_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int MULDIV_LAT = 8,
  parameter int CNT_W      = $clog2(MULDIV_LAT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] Rs_ID,
  input  logic [REG_W-1:0] Rt_ID,
  input  logic             UsesRt_ID,
  input  logic [REG_W-1:0] Dst_EX,
  input  logic             RegWrite_EX,
  input  logic             MemRead_EX,
  input  logic [REG_W-1:0] Dst_MEM,
  input  logic             MemRead_MEM,
  input  logic             Branch_ID,
  input  logic             BranchTaken_ID,
  input  logic             MulDiv_ID,
  input  logic             HiLoRead_ID,
`ifdef HAZARD_STATS_EN
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_count,
`endif
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             ID_EX_Flush,
  output logic             IF_ID_Flush,
  output logic             MulDiv_Start,
  output logic             MulDiv_Busy
);

  logic dep_ex;
  logic dep_mem;
  logic load_use;
  logic br_ex;
  logic br_mem;
  logic md_stall;
  logic stall;

  assign dep_ex  = reg_hit(Rs_ID, Dst_EX)  || (UsesRt_ID && reg_hit(Rt_ID, Dst_EX));
  assign dep_mem = reg_hit(Rs_ID, Dst_MEM) || (UsesRt_ID && reg_hit(Rt_ID, Dst_MEM));

  assign load_use = MemRead_EX && dep_ex;
  // Branches compare in ID, so even ALU results in EX are too late to forward.
  assign br_ex    = Branch_ID && RegWrite_EX && dep_ex;
  assign br_mem   = Branch_ID && MemRead_MEM && dep_mem;
  assign md_stall = MulDiv_Busy && (HiLoRead_ID || MulDiv_ID);
  assign stall    = load_use | br_ex | br_mem | md_stall;

  assign PCWrite     = !stall;
  assign IF_ID_Write = !stall;
  assign ID_EX_Flush = stall;
  assign IF_ID_Flush = BranchTaken_ID && !stall;

  muldiv_sequencer #(
    .MULDIV_LAT (MULDIV_LAT),
    .CNT_W      (CNT_W)
  ) u_muldiv_sequencer (
    .clk   (clk),
    .rst_n (rst_n),
    .issue (MulDiv_ID),
    .stall (stall),
    .start (MulDiv_Start),
    .busy  (MulDiv_Busy)
  );

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (IF_ID_Flush) begin
      flush_count_d = flush_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule
